// File: rtl/qspi_flash_reader.sv
// QSPI master: quad I/O fast read (0xEB) streaming 32-bit little-endian words to the page cache.
module qspi_flash_reader #(
    parameter int unsigned INIT_DELAY      = 16,
    parameter int unsigned CSB_HIGH_CYCLES = 4,
    parameter int unsigned DUMMY_CLOCKS    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        qspi_enable,
    input  logic [23:0] qspi_address,
    input  logic        qspi_changeAddress,
    input  logic        qspi_requestData,
    output logic [31:0] qspi_readData,
    output logic        qspi_readDataValid,
    output logic        qspi_initialised,
    output logic        qspi_busy,
    output logic        flash_csb,
    output logic        flash_sck,
    output logic [3:0]  flash_io_we,
    output logic [3:0]  flash_io_write,
    input  logic [3:0]  flash_io_read
);

    localparam int unsigned CNT_W  = 8;
    localparam logic [7:0]  CMD_EB = 8'hEB;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_READY, S_CSB_GAP, S_CMD,
        S_ADDR, S_MODE, S_DUMMY, S_DATA, S_PAUSE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [23:0]        addr_q, addr_d;
    logic [31:0]        shift_q, shift_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               valid_q, valid_d;
    logic               init_q, init_d;
    logic               busy_q, busy_d;
    logic               csb_q, csb_d;
    logic               sck_q, sck_d;
    logic [3:0]         io_we_q, io_we_d;
    logic [3:0]         io_wr_q, io_wr_d;
    logic [CNT_W-1:0]   slot_last;
    state_t             slot_nxt;

    // Pad drive {we, data} for a given setup-phase slot; presented during that slot's L phase.
    function automatic logic [7:0] slot_out(input state_t st, input logic [2:0] idx,
                                            input logic [23:0] addr);
        logic [7:0]  cmd_sh;
        logic [23:0] addr_sh;
        slot_out = 8'h00;
        cmd_sh   = CMD_EB >> (3'd7 - idx);
        addr_sh  = addr >> (5'd20 - {idx, 2'b00});
        case (st)
            S_CMD:   slot_out = {4'b0001, 3'b000, cmd_sh[0]};
            S_ADDR:  slot_out = {4'b1111, addr_sh[3:0]};
            S_MODE:  slot_out = {4'b1111, 4'b0000};
            default: slot_out = 8'h00;
        endcase
    endfunction

    // Next-state, SCK phase sequencing, data assembly and pad drive.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        shift_d   = shift_q;
        rdata_d   = rdata_q;
        valid_d   = 1'b0;
        csb_d     = csb_q;
        sck_d     = sck_q;
        io_we_d   = io_we_q;
        io_wr_d   = io_wr_q;
        slot_last = '0;
        slot_nxt  = S_IDLE;

        case (state_q)
            S_CMD:   begin slot_last = CNT_W'(7); slot_nxt = S_ADDR;  end
            S_ADDR:  begin slot_last = CNT_W'(5); slot_nxt = S_MODE;  end
            S_MODE:  begin slot_last = CNT_W'(1); slot_nxt = S_DUMMY; end
            S_DUMMY: begin
                slot_last = CNT_W'(DUMMY_CLOCKS - 1);
                slot_nxt  = qspi_requestData ? S_DATA : S_PAUSE;
            end
            default: ;
        endcase

        if (!qspi_enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            csb_d   = 1'b1;
            sck_d   = 1'b0;
            io_we_d = 4'h0;
            io_wr_d = 4'h0;
        end else if (qspi_changeAddress &&
                     (state_q == S_READY || state_q == S_DATA || state_q == S_PAUSE)) begin
            // Abandon any word in flight and reopen the device at the new address.
            state_d = S_CSB_GAP;
            cnt_d   = '0;
            addr_d  = qspi_address & 24'hFF_FFFC;
            csb_d   = 1'b1;
            sck_d   = 1'b0;
            io_we_d = 4'h0;
            io_wr_d = 4'h0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                end
                S_INIT: begin
                    if (cnt_q == CNT_W'(INIT_DELAY - 1)) begin
                        state_d = S_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CSB_GAP: begin
                    if (cnt_q == CNT_W'(CSB_HIGH_CYCLES - 1)) begin
                        state_d            = S_CMD;
                        cnt_d              = '0;
                        csb_d              = 1'b0;
                        {io_we_d, io_wr_d} = slot_out(S_CMD, 3'd0, addr_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_CMD, S_ADDR, S_MODE, S_DUMMY: begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        sck_d = 1'b0;
                        if (cnt_q == slot_last) begin
                            state_d = slot_nxt;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                        {io_we_d, io_wr_d} = slot_out(state_d, cnt_d[2:0], addr_q);
                    end
                end
                S_DATA: begin
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else begin
                        // Sample on the cycle SCK falls; first byte lands in bits [7:0].
                        sck_d   = 1'b0;
                        shift_d = {shift_q[27:0], flash_io_read};
                        if (cnt_q == CNT_W'(7)) begin
                            rdata_d = {shift_d[7:0], shift_d[15:8], shift_d[23:16], shift_d[31:24]};
                            valid_d = 1'b1;
                            cnt_d   = '0;
                            state_d = qspi_requestData ? S_DATA : S_PAUSE;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_PAUSE: begin
                    if (qspi_requestData) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                default: ;
            endcase
        end

        busy_d = (state_d == S_INIT) || (state_d == S_CSB_GAP) || (state_d == S_CMD) ||
                 (state_d == S_ADDR) || (state_d == S_MODE)    || (state_d == S_DUMMY);
        init_d = (state_d != S_IDLE) && (state_d != S_INIT);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            init_q  <= 1'b0;
            busy_q  <= 1'b0;
            csb_q   <= 1'b1;
            sck_q   <= 1'b0;
            io_we_q <= 4'h0;
            io_wr_q <= 4'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            init_q  <= init_d;
            busy_q  <= busy_d;
            csb_q   <= csb_d;
            sck_q   <= sck_d;
            io_we_q <= io_we_d;
            io_wr_q <= io_wr_d;
        end
    end

    assign qspi_readData      = rdata_q;
    assign qspi_readDataValid = valid_q;
    assign qspi_initialised   = init_q;
    assign qspi_busy          = busy_q;
    assign flash_csb          = csb_q;
    assign flash_sck          = sck_q;
    assign flash_io_we        = io_we_q;
    assign flash_io_write     = io_wr_q;

endmodule

// File: tb/tb_qspi_flash_reader.sv
// Directed bench for qspi_flash_reader with a behavioural quad-I/O NOR flash model.
module tb_qspi_flash_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        qspi_enable;
    logic [23:0] qspi_address;
    logic        qspi_changeAddress;
    logic        qspi_requestData;
    logic [31:0] qspi_readData;
    logic        qspi_readDataValid;
    logic        qspi_initialised;
    logic        qspi_busy;
    logic        flash_csb;
    logic        flash_sck;
    logic [3:0]  flash_io_we;
    logic [3:0]  flash_io_write;
    logic [3:0]  flash_io_read = 4'h0;

    int total = 0;
    int bad   = 0;

    qspi_flash_reader dut (
        .clk                (clk),
        .rst                (rst),
        .qspi_enable        (qspi_enable),
        .qspi_address       (qspi_address),
        .qspi_changeAddress (qspi_changeAddress),
        .qspi_requestData   (qspi_requestData),
        .qspi_readData      (qspi_readData),
        .qspi_readDataValid (qspi_readDataValid),
        .qspi_initialised   (qspi_initialised),
        .qspi_busy          (qspi_busy),
        .flash_csb          (flash_csb),
        .flash_sck          (flash_sck),
        .flash_io_we        (flash_io_we),
        .flash_io_write     (flash_io_write),
        .flash_io_read      (flash_io_read)
    );

    always #5 clk = ~clk;

    // Flash model: decodes command/address/mode from SCK rising edges, drives data after each rise.
    logic [7:0]  mem [0:2047];
    int          sck_cnt = 0;
    logic [7:0]  m_cmd   = 8'h00;
    logic [23:0] m_addr  = 24'h0;
    logic [7:0]  m_mode  = 8'hFF;

    always @(posedge flash_csb) sck_cnt = 0;

    always @(posedge flash_sck) begin
        int          k;
        logic [10:0] idx;
        logic [7:0]  b;
        if (sck_cnt < 8)       m_cmd  = {m_cmd[6:0], flash_io_write[0]};
        else if (sck_cnt < 14) m_addr = {m_addr[19:0], flash_io_write};
        else if (sck_cnt < 16) m_mode = {m_mode[3:0], flash_io_write};
        else if (sck_cnt >= 20) begin
            k   = sck_cnt - 20;
            idx = m_addr[10:0] + 11'(k >> 1);
            b   = mem[idx];
            flash_io_read = k[0] ? b[3:0] : b[7:4];
        end
        sck_cnt = sck_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic change(input logic [23:0] a);
        qspi_address       = a;
        qspi_changeAddress = 1'b1;
        tick();
        qspi_changeAddress = 1'b0;
    endtask

    // Returns cycles until the next valid pulse (0 if none within max) and the word seen.
    task automatic wait_valid(input int max, output int n, output logic [31:0] d);
        n = 0;
        d = 32'hDEAD_BEEF;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (qspi_readDataValid) begin
                n = i;
                d = qspi_readData;
                break;
            end
        end
    endtask

    task automatic run_init();
        int nb;
        int nl;
        nb = 0;
        nl = 0;
        qspi_enable = 1'b1;
        for (int i = 0; i < 40 && !qspi_initialised; i++) begin
            tick();
            if (qspi_busy && !qspi_initialised) nb++;
            if (!flash_csb) nl++;
        end
        chk("init_busy_cycles", 32'(nb), 32'd16);
        chk("init_done", 32'(qspi_initialised), 32'd1);
        chk("init_csb_low", 32'(nl), 32'd0);
    endtask

    initial begin
        int          n;
        int          cnt;
        logic [31:0] d;

        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        for (int i = 0; i < 15; i++) mem[12'h200 + i] = 8'(17 * (i + 1));
        for (int i = 0; i < 4; i++) mem[12'h400 + i] = 8'(8'hA0 + i);

        rst = 1'b1;
        qspi_enable = 1'b0;
        qspi_address = 24'h0;
        qspi_changeAddress = 1'b0;
        qspi_requestData = 1'b0;
        repeat (3) tick();
        chk("rst_outs", {qspi_readData[15:0], 8'h0, qspi_readDataValid, qspi_initialised,
                         qspi_busy, flash_csb, flash_sck, 3'b0},
            32'h0000_0010);
        chk("rst_pads", {24'h0, flash_io_we, flash_io_write}, 32'h0);
        chk("rst_rdata", qspi_readData, 32'h0);
        rst = 1'b0;
        tick();
        chk("idle_not_busy", 32'(qspi_busy), 32'd0);

        run_init();

        // First word from 0x200: latency and decode of the serial header.
        qspi_requestData = 1'b1;
        change(24'h000200);
        wait_valid(100, n, d);
        chk("latency", 32'(n + 1), 32'd61);
        chk("word1", d, 32'h4433_2211);
        chk("cmd", 32'(m_cmd), 32'h0000_00EB);
        chk("addr", 32'(m_addr), 32'h0000_0200);
        chk("mode", 32'(m_mode), 32'h0);
        tick();
        chk("valid_pulse", 32'(qspi_readDataValid), 32'd0);
        chk("rdata_hold", qspi_readData, 32'h4433_2211);

        // Word 2, drop request mid-word 3, then pause.
        wait_valid(40, n, d);
        chk("word2", d, 32'h8877_6655);
        qspi_requestData = 1'b0;
        wait_valid(40, n, d);
        chk("word3", d, 32'hCCBB_AA99);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (flash_csb || flash_sck || qspi_readDataValid) cnt++;
        end
        chk("pause_static", 32'(cnt), 32'd0);
        qspi_requestData = 1'b1;
        wait_valid(40, n, d);
        chk("resume_lat", 32'(n), 32'd17);
        chk("word4", d, 32'h00FF_EEDD);

        // Mid-word address change; low address bits ignored; change while busy ignored.
        repeat (6) tick();
        change(24'h000403);
        cnt = 0;
        n = 0;
        for (int i = 0; i < 20 && flash_csb; i++) begin
            cnt++;
            if (qspi_readDataValid) n++;
            tick();
        end
        chk("csb_gap", 32'(cnt), 32'd4);
        chk("gap_no_valid", 32'(n), 32'd0);
        tick();
        chk("busy_cmd", 32'(qspi_busy), 32'd1);
        change(24'h000300);
        wait_valid(80, n, d);
        chk("word_400", d, 32'hA3A2_A1A0);
        chk("addr_400", 32'(m_addr), 32'h0000_0400);
        chk("cmd_400", 32'(m_cmd), 32'h0000_00EB);

        // Enable dropped during ADDR.
        change(24'h000200);
        repeat (24) tick();
        chk("in_addr_we", 32'(flash_io_we), 32'hF);
        qspi_enable = 1'b0;
        tick();
        chk("abort_outs", {27'h0, flash_csb, flash_sck, qspi_initialised, qspi_busy,
                           qspi_readDataValid}, 32'h10);
        chk("abort_we", 32'(flash_io_we), 32'h0);
        repeat (2) tick();

        run_init();
        change(24'h000200);
        wait_valid(100, n, d);
        chk("reinit_word", d, 32'h4433_2211);
        chk("reinit_lat", 32'(n + 1), 32'd61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
